// File: rtl/sort_pkg.sv
// Shared definitions for the sort stream controller: state encoding, pad selection
// and the slot packing helper that matches the sorter tops.
package sort_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_FIRE  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Pads must sort to the tail under unsigned ordering, so each pad bit
    // equals the sort direction; the caller replicates it across DATA_WIDTH.
    function automatic logic pad_fill(input bit ascending);
        return ascending;
    endfunction

    function automatic int slot_lsb(input int slot, input int data_width);
        return slot * data_width;
    endfunction

endpackage

// File: rtl/sort_frame_buf.sv
// N-entry frame register array with a single-word write port, a whole-frame parallel
// load, and a packed read bus where slots at or beyond valid_cnt read as the pad value.
module sort_frame_buf
    import sort_pkg::*;
#(
    parameter int LOG_N      = 4,
    parameter int DATA_WIDTH = 32,
    parameter bit PAD_BIT    = 1'b1
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [LOG_N-1:0]              wr_addr,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          ld_en,
    input  logic [DATA_WIDTH*(1<<LOG_N)-1:0] ld_data,
    input  logic [LOG_N:0]                valid_cnt,
    output logic [DATA_WIDTH*(1<<LOG_N)-1:0] rd_bus
);

    localparam int N  = 1 << LOG_N;
    localparam int CW = LOG_N + 1;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slot
            localparam logic [LOG_N-1:0] ADDR = LOG_N'(gi);
            localparam logic [CW-1:0]    SLOT = CW'(gi);

            logic [DATA_WIDTH-1:0] slot_reg;

            always_ff @(posedge clk) begin
                if (ld_en) begin
                    slot_reg <= ld_data[slot_lsb(gi, DATA_WIDTH) +: DATA_WIDTH];
                end else if (wr_en && (wr_addr == ADDR)) begin
                    slot_reg <= wr_data;
                end
            end

            assign rd_bus[slot_lsb(gi, DATA_WIDTH) +: DATA_WIDTH] =
                (SLOT < valid_cnt) ? slot_reg : {DATA_WIDTH{PAD_BIT}};
        end
    endgenerate

endmodule

// File: rtl/sort_stream_ctrl.sv
// Frame sequencer between a word-serial stream and a parallel sorting network.
// Optional WAIT watchdog compiled in with `define SORT_CTRL_TIMEOUT_EN.
module sort_stream_ctrl
    import sort_pkg::*;
#(
    parameter int LOG_INPUT_NUM  = 4,
    parameter int DATA_WIDTH     = 32,
    parameter bit ASCENDING      = 1'b1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [DATA_WIDTH-1:0]                  s_data,
    input  logic                                   s_valid,
    input  logic                                   s_last,
    output logic                                   s_ready,
    output logic [DATA_WIDTH-1:0]                  m_data,
    output logic                                   m_valid,
    output logic                                   m_last,
    input  logic                                   m_ready,
    output logic [DATA_WIDTH*(1<<LOG_INPUT_NUM)-1:0] sort_x,
    output logic                                   sort_x_valid,
    input  logic [DATA_WIDTH*(1<<LOG_INPUT_NUM)-1:0] sort_y,
    input  logic                                   sort_y_valid,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   err
);

    localparam int            N        = 1 << LOG_INPUT_NUM;
    localparam int            CW       = LOG_INPUT_NUM + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(N);

    state_t              state_reg, state_next;
    logic [CW-1:0]       wr_cnt_reg, wr_cnt_next;
    logic [CW-1:0]       rd_cnt_reg, rd_cnt_next;
    logic [CW-1:0]       count_reg, count_next;
    logic [DATA_WIDTH*N-1:0] obuf_bus;
    logic                timeout;
    logic                y_take;

    assign s_ready      = !rst && (state_reg == ST_LOAD);
    assign sort_x_valid = !rst && (state_reg == ST_FIRE);
    assign m_valid      = !rst && (state_reg == ST_DRAIN);
    assign busy         = !rst && (state_reg != ST_LOAD);
    assign m_last       = m_valid && (rd_cnt_reg == count_reg - CW'(1));
    assign done         = m_valid && m_ready && m_last;
    assign y_take       = (state_reg == ST_WAIT) && sort_y_valid;
    assign err          = timeout;

    // The load buffer is only written in LOAD, so sort_x stays stable from FIRE
    // until the result is captured even if the sorter samples it late.
    sort_frame_buf #(
        .LOG_N      (LOG_INPUT_NUM),
        .DATA_WIDTH (DATA_WIDTH),
        .PAD_BIT    (pad_fill(ASCENDING))
    ) u_load_buf (
        .clk       (clk),
        .wr_en     (s_ready && s_valid),
        .wr_addr   (wr_cnt_reg[LOG_INPUT_NUM-1:0]),
        .wr_data   (s_data),
        .ld_en     (1'b0),
        .ld_data   ('0),
        .valid_cnt (count_reg),
        .rd_bus    (sort_x)
    );

    sort_frame_buf #(
        .LOG_N      (LOG_INPUT_NUM),
        .DATA_WIDTH (DATA_WIDTH),
        .PAD_BIT    (pad_fill(ASCENDING))
    ) u_out_buf (
        .clk       (clk),
        .wr_en     (1'b0),
        .wr_addr   ('0),
        .wr_data   ('0),
        .ld_en     (y_take),
        .ld_data   (sort_y),
        .valid_cnt (FULL_CNT),
        .rd_bus    (obuf_bus)
    );

    always_comb begin
        m_data = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(rd_cnt_reg) == i) begin
                m_data = obuf_bus[slot_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
            end
        end
    end

`ifdef SORT_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wd_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || (state_reg != ST_WAIT)) begin
            wd_cnt_reg <= '0;
        end else begin
            wd_cnt_reg <= wd_cnt_reg + TW'(1);
        end
    end

    assign timeout = !rst && (state_reg == ST_WAIT) && !sort_y_valid &&
                     (wd_cnt_reg == TW'(TIMEOUT_CYCLES - 1));
`else
    // Watchdog compiled out: the comparison is always false for a valid limit.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_LOAD;
            wr_cnt_reg <= '0;
            rd_cnt_reg <= '0;
            count_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            wr_cnt_reg <= wr_cnt_next;
            rd_cnt_reg <= rd_cnt_next;
            count_reg  <= count_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        wr_cnt_next = wr_cnt_reg;
        rd_cnt_next = rd_cnt_reg;
        count_next  = count_reg;
        case (state_reg)
            ST_LOAD: begin
                if (s_valid) begin
                    wr_cnt_next = wr_cnt_reg + CW'(1);
                    if (s_last || (wr_cnt_reg == LAST_IDX)) begin
                        count_next = wr_cnt_reg + CW'(1);
                        state_next = ST_FIRE;
                    end
                end
            end
            ST_FIRE: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (sort_y_valid) begin
                    rd_cnt_next = '0;
                    state_next  = ST_DRAIN;
                end else if (timeout) begin
                    wr_cnt_next = '0;
                    rd_cnt_next = '0;
                    count_next  = '0;
                    state_next  = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (m_ready) begin
                    rd_cnt_next = rd_cnt_reg + CW'(1);
                    if (m_last) begin
                        wr_cnt_next = '0;
                        state_next  = ST_LOAD;
                    end
                end
            end
            default: state_next = ST_LOAD;
        endcase
    end

endmodule

// File: tb/tb_sort_stream_ctrl.sv
// Scoreboard bench for sort_stream_ctrl with a latency-3 behavioural sorter.
// Define SORT_CTRL_TIMEOUT_EN to also exercise the watchdog.
module tb_sort_stream_ctrl;

    localparam int LOG_N = 2;
    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int LAT   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [DW-1:0]   s_data  = '0;
    logic            s_valid = 1'b0;
    logic            s_last  = 1'b0;
    logic            s_ready;
    logic [DW-1:0]   m_data;
    logic            m_valid, m_last;
    logic            m_ready = 1'b1;
    logic [DW*N-1:0] sort_x, sort_y;
    logic            sort_x_valid, sort_y_valid;
    logic            busy, done, err;

    always #5 clk = ~clk;

    sort_stream_ctrl #(
        .LOG_INPUT_NUM  (LOG_N),
        .DATA_WIDTH     (DW),
        .ASCENDING      (1'b1),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_last       (m_last),
        .m_ready      (m_ready),
        .sort_x       (sort_x),
        .sort_x_valid (sort_x_valid),
        .sort_y       (sort_y),
        .sort_y_valid (sort_y_valid),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Behavioural sorter: samples sort_x late, in the cycle it presents the result.
    function automatic logic [DW*N-1:0] sort_pack(input logic [DW*N-1:0] x);
        logic [DW-1:0] a [N];
        logic [DW-1:0] t;
        for (int i = 0; i < N; i++) a[i] = x[i*DW +: DW];
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N - 1 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        sort_pack = '0;
        for (int i = 0; i < N; i++) sort_pack[i*DW +: DW] = a[i];
    endfunction

    logic [LAT-1:0] y_pipe = '0;
    bit             sorter_silent = 1'b0;
    always @(posedge clk) y_pipe <= {y_pipe[LAT-2:0], sort_x_valid};
    assign sort_y_valid = y_pipe[LAT-1] && !sorter_silent;
    assign sort_y       = sort_pack(sort_x);

    logic [DW-1:0]   fr [N];
    logic [DW*N-1:0] exp_x = '0;
    logic [DW-1:0]   exp_data [$];
    bit              exp_last [$];

    int cyc = 0, fire_cnt = 0, done_cnt = 0, err_cnt = 0, fire_cyc = 0;
    bit first_out = 1'b0;
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (sort_x_valid) begin
                fire_cnt++;
                fire_cyc  = cyc;
                first_out = 1'b1;
                chk("sort_x", sort_x, exp_x);
            end
            if (m_valid && first_out) begin
                chk("first_out_latency", cyc - fire_cyc, LAT + 1);
                first_out = 1'b0;
            end
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1'b1);
                chk("stall_data", m_data, prev_data);
                chk("stall_last", m_last, prev_last);
            end
            if (m_valid) chk("s_ready_in_drain", s_ready, 1'b0);
            if (m_valid && exp_data.size() == 0) begin
                chk("spurious_m_valid", m_valid, 1'b0);
            end else if (m_valid && m_ready) begin
                $display("OUT data=%0h last=%0b", m_data, m_last);
                chk("m_data", m_data, exp_data.pop_front());
                chk("m_last", m_last, exp_last.pop_front());
            end
            if (done) begin
                done_cnt++;
                chk("done_on_last_hs", m_valid && m_ready && m_last, 1'b1);
            end
            if (err) err_cnt++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    // Sends fr[0..len-1]; returns at the negedge of the expected FIRE cycle.
    task automatic send_frame(input int len, input bit use_last, input int gap, input bit push_exp);
        logic [DW*N-1:0] srt;
        exp_x = '1;
        for (int i = 0; i < len; i++) exp_x[i*DW +: DW] = fr[i];
        srt = sort_pack(exp_x);
        if (push_exp)
            for (int i = 0; i < len; i++) begin
                exp_data.push_back(srt[i*DW +: DW]);
                exp_last.push_back(i == len - 1);
            end
        for (int i = 0; i < len; i++) begin
            int k;
            s_data  = fr[i];
            s_valid = 1'b1;
            s_last  = use_last && (i == len - 1);
            k = 0;
            @(negedge clk);
            while (!s_ready && k < 200) begin
                @(negedge clk);
                k++;
            end
            if (!s_ready) chk("s_ready_wait", s_ready, 1'b1);
            $display("IN  data=%0h last=%0b", s_data, s_last);
            @(posedge clk); #1;
            s_valid = 1'b0;
            s_last  = 1'b0;
            if (i < len - 1)
                repeat (gap) begin
                    @(negedge clk);
                    chk("busy_in_gap", busy, 1'b0);
                    chk("s_ready_in_gap", s_ready, 1'b1);
                    @(posedge clk); #1;
                end
        end
        @(negedge clk);
        chk("fire_after_last_in", sort_x_valid, 1'b1);
    endtask

    task automatic drain(input logic [3:0] pat, input int budget);
        int start, k, n;
        start = done_cnt;
        k = 0;
        n = 0;
        while (done_cnt == start && n < budget) begin
            if (m_valid) begin
                m_ready = pat[k % 4];
                k++;
            end else begin
                m_ready = 1'b1;
            end
            @(posedge clk); #1;
            n++;
        end
        m_ready = 1'b1;
        chk("done_once", done_cnt, start + 1);
        chk("s_ready_after_done", s_ready, 1'b1);
        chk("busy_after_done", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_x_valid", sort_x_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready", s_ready, 1'b1);
        @(posedge clk); #1;

        // full frame closed by count, no s_last
        fr[0] = 7; fr[1] = 3; fr[2] = 9; fr[3] = 1;
        send_frame(4, 1'b0, 0, 1'b1);
        drain(4'b1111, 100);

        // short frame with padding
        fr[0] = 5; fr[1] = 2;
        send_frame(2, 1'b1, 0, 1'b1);
        drain(4'b1111, 100);

        // backpressure pattern 1,0,0,1
        fr[0] = 7; fr[1] = 3; fr[2] = 9; fr[3] = 1;
        send_frame(4, 1'b0, 0, 1'b1);
        drain(4'b1001, 200);

        // input gaps of two cycles
        fr[0] = 32'hdead_beef; fr[1] = 32'h10; fr[2] = 32'hffff_ffff; fr[3] = 32'h0;
        send_frame(4, 1'b0, 2, 1'b1);
        drain(4'b1111, 100);

        // single-word frame
        fr[0] = 42;
        send_frame(1, 1'b1, 0, 1'b1);
        drain(4'b1111, 100);

        // reset during WAIT drops the frame; the late sort_y_valid must be ignored
        fr[0] = 6; fr[1] = 5;
        send_frame(2, 1'b1, 0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_s_ready", s_ready, 1'b1);
        chk("midrst_m_valid", m_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        repeat (6) begin
            @(negedge clk);
            chk("stale_y_m_valid", m_valid, 1'b0);
            chk("stale_y_busy", busy, 1'b0);
        end
        @(posedge clk); #1;
        fr[0] = 4; fr[1] = 4; fr[2] = 0; fr[3] = 8;
        send_frame(4, 1'b0, 0, 1'b1);
        drain(4'b1111, 100);

`ifdef SORT_CTRL_TIMEOUT_EN
        sorter_silent = 1'b1;
        fr[0] = 2; fr[1] = 1;
        send_frame(2, 1'b1, 0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("timeout_err", err, k == 10);
        end
        @(negedge clk);
        chk("timeout_busy", busy, 1'b0);
        chk("timeout_s_ready", s_ready, 1'b1);
        repeat (5) begin
            @(negedge clk);
            chk("timeout_m_valid", m_valid, 1'b0);
        end
        chk("err_pulses", err_cnt, 1);
        chk("fire_total", fire_cnt, 8);
`else
        chk("err_pulses", err_cnt, 0);
        chk("fire_total", fire_cnt, 7);
`endif
        chk("done_total", done_cnt, 6);
        chk("scoreboard_empty", exp_data.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
